// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: column drive, row sync, scan-level debounce
// of single-key presses, and a show-ahead code FIFO with a sticky overflow flag.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 12500,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [3:0]                    col_out,
    input  logic [3:0]                    row_in,
    input  logic                          rd_en,
    output logic [3:0]                    dout_code,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          key_down
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD, S_RELEASE} state_t;

    function automatic logic [4:0] f_popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    logic [3:0]        r_row_s1, r_row_s2;
    logic              r_active;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_col;
    logic [15:0]       r_snap;
    logic              r_scan_done;

    state_t            r_state, w_state_nxt;
    logic [DEB_W-1:0]  r_cnt, w_cnt_nxt;
    logic [3:0]        r_code, w_code_nxt;
    logic              w_push;
    logic [4:0]        w_ones;
    logic [3:0]        w_cand;
    logic              w_single, w_last;

    logic [3:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_rd_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic [3:0]        r_dout, w_head_nxt;
    logic              r_empty, r_overflow;
    logic              w_full, w_do_pop, w_do_push;

    // Two-flop synchroniser on the asynchronous row lines
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row_in;
            r_row_s2 <= r_row_s1;
        end
    end

    // Column dwell timing; rows are sampled on the final cycle of each dwell
    always_ff @(posedge clk) begin
        r_scan_done <= 1'b0;
        if (rst) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_col    <= '0;
        end else if (!r_active) begin
            r_active <= 1'b1;
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div                       <= '0;
            r_col                       <= r_col + 2'd1;
            r_snap[{r_col, 2'b00} +: 4] <= ~r_row_s2;
            r_scan_done                 <= (r_col == 2'd3);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign col_out = r_active ? ~(4'b0001 << r_col) : 4'b1111;

    always_comb begin
        w_ones = f_popcount(r_snap);
        w_cand = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_snap[i]) w_cand = i[3:0];
        end
    end

    assign w_single = (w_ones == 5'd1);
    assign w_last   = (r_cnt == DEB_W'(DEBOUNCE_SCANS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // Debounce FSM, evaluated once per completed scan; multi-key scans never confirm
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_push      = 1'b0;
        if (r_scan_done) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_code_nxt = w_cand;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_push      = 1'b1;
                            w_state_nxt = S_HELD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_CONFIRM;
                            w_cnt_nxt   = DEB_W'(1);
                        end
                    end
                end
                S_CONFIRM: begin
                    if (w_single && (w_cand == r_code)) begin
                        if (w_last) begin
                            w_push      = 1'b1;
                            w_state_nxt = S_HELD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + DEB_W'(1);
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_HELD: begin
                    if (w_ones == 5'd0) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_RELEASE;
                            w_cnt_nxt   = DEB_W'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    if (w_ones == 5'd0) begin
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + DEB_W'(1);
                        end
                    end else begin
                        w_state_nxt = S_HELD;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign key_down = (r_state == S_HELD) || (r_state == S_RELEASE);

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_do_pop  = rd_en && (r_count != '0);
    assign w_do_push = w_push && (!w_full || w_do_pop);
    assign w_rd_nxt  = w_do_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    // Show-ahead head: when the next head slot is being written this cycle, bypass the write data
    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop)      w_count_nxt = r_count + CNT_W'(1);
        else if (!w_do_push && w_do_pop) w_count_nxt = r_count - CNT_W'(1);
        if (w_count_nxt == '0)                         w_head_nxt = 4'h0;
        else if (w_do_push && (w_rd_nxt == r_wr_ptr))  w_head_nxt = w_code_nxt;
        else                                           w_head_nxt = r_mem[w_rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= w_code_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dout     <= 4'h0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_dout   <= w_head_nxt;
            r_empty  <= (w_count_nxt == '0);
            if (w_push && w_full && !w_do_pop) r_overflow <= 1'b1;
        end
    end

    assign dout_code  = r_dout;
    assign fifo_empty = r_empty;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
